// File: rtl/rom_rd_arbiter.sv
// Two-master AXI read-address/read-data arbiter in front of the single ROM read slave.
// Define ROM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default build is fixed priority (M0 wins).
module rom_rd_arbiter #(
    parameter int ID_BITS   = 4,
    parameter int ADDR_BITS = 12,
    parameter int LEN_BITS  = 4
) (
    input  logic                 ACLK,
    input  logic                 ARESET,

    input  logic [ID_BITS-1:0]   ARID_M0,
    input  logic [ADDR_BITS-1:0] ARADDR_M0,
    input  logic [LEN_BITS-1:0]  ARLEN_M0,
    input  logic                 ARVALID_M0,
    output logic                 ARREADY_M0,
    output logic [ID_BITS-1:0]   RID_M0,
    output logic [1:0]           RRESP_M0,
    output logic                 RLAST_M0,
    output logic                 RVALID_M0,
    input  logic                 RREADY_M0,

    input  logic [ID_BITS-1:0]   ARID_M1,
    input  logic [ADDR_BITS-1:0] ARADDR_M1,
    input  logic [LEN_BITS-1:0]  ARLEN_M1,
    input  logic                 ARVALID_M1,
    output logic                 ARREADY_M1,
    output logic [ID_BITS-1:0]   RID_M1,
    output logic [1:0]           RRESP_M1,
    output logic                 RLAST_M1,
    output logic                 RVALID_M1,
    input  logic                 RREADY_M1,

    output logic [ID_BITS-1:0]   ARID_S,
    output logic [ADDR_BITS-1:0] ARADDR_S,
    output logic [LEN_BITS-1:0]  ARLEN_S,
    output logic                 ARVALID_S,
    input  logic                 ARREADY_S,
    input  logic [ID_BITS-1:0]   RID_S,
    input  logic [1:0]           RRESP_S,
    input  logic                 RLAST_S,
    input  logic                 RVALID_S,
    output logic                 RREADY_S,

    output logic                 grant,
    output logic                 busy,
    output logic                 beat_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [LEN_BITS-1:0] LEN_ONE = {{(LEN_BITS-1){1'b0}}, 1'b1};

    state_t               state;
    state_t               next_state;
    logic                 sel;
    logic                 ar_hs;
    logic                 beat_hs;
    logic                 r_ready_sel;
    logic [ID_BITS-1:0]   lat_id;
    logic [ADDR_BITS-1:0] lat_addr;
    logic [LEN_BITS-1:0]  lat_len;
    logic [LEN_BITS-1:0]  beat_cnt;

    // sel = 1 picks M1; only meaningful in IDLE with at least one request.
`ifdef ROM_ARB_ROUND_ROBIN_EN
    logic ptr;

    always_comb begin
        if (ARVALID_M0 && ARVALID_M1) begin
            sel = ptr;
        end else begin
            sel = ARVALID_M1;
        end
    end
`else
    always_comb begin
        sel = ARVALID_M1 && !ARVALID_M0;
    end
`endif

    always_comb begin
        ar_hs       = (state == IDLE) && (ARVALID_M0 || ARVALID_M1);
        r_ready_sel = grant ? RREADY_M1 : RREADY_M0;
        beat_hs     = (state == DATA) && RVALID_S && r_ready_sel;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (ar_hs) begin
                    next_state = ADDR;
                end
            end
            ADDR: begin
                if (ARREADY_S) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (beat_hs && RLAST_S) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The burst always ends on RLAST_S; the counter only drives the length check.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            lat_id   <= '0;
            lat_addr <= '0;
            lat_len  <= '0;
            grant    <= 1'b0;
            beat_cnt <= '0;
            beat_err <= 1'b0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
            ptr      <= 1'b0;
`endif
        end else begin
            if (ar_hs) begin
                grant <= sel;
`ifdef ROM_ARB_ROUND_ROBIN_EN
                ptr   <= !sel;
`endif
                if (sel) begin
                    lat_id   <= ARID_M1;
                    lat_addr <= ARADDR_M1;
                    lat_len  <= ARLEN_M1;
                end else begin
                    lat_id   <= ARID_M0;
                    lat_addr <= ARADDR_M0;
                    lat_len  <= ARLEN_M0;
                end
            end

            if ((state == ADDR) && ARREADY_S) begin
                beat_cnt <= lat_len;
            end else if (beat_hs) begin
                if (beat_cnt != '0) begin
                    beat_cnt <= beat_cnt - LEN_ONE;
                end
            end

            if (beat_hs && ((RLAST_S && (beat_cnt != '0)) ||
                            (!RLAST_S && (beat_cnt == '0)))) begin
                beat_err <= 1'b1;
            end
        end
    end

    always_comb begin
        ARREADY_M0 = 1'b0;
        ARREADY_M1 = 1'b0;
        RID_M0     = '0;
        RRESP_M0   = 2'b00;
        RLAST_M0   = 1'b0;
        RVALID_M0  = 1'b0;
        RID_M1     = '0;
        RRESP_M1   = 2'b00;
        RLAST_M1   = 1'b0;
        RVALID_M1  = 1'b0;
        ARVALID_S  = 1'b0;
        RREADY_S   = 1'b0;
        ARID_S     = lat_id;
        ARADDR_S   = lat_addr;
        ARLEN_S    = lat_len;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                ARREADY_M0 = ARVALID_M0 && !sel;
                ARREADY_M1 = ARVALID_M1 && sel;
            end
            ADDR: begin
                ARVALID_S = 1'b1;
            end
            DATA: begin
                RREADY_S = r_ready_sel;
                if (grant) begin
                    RID_M1    = RID_S;
                    RRESP_M1  = RRESP_S;
                    RLAST_M1  = RLAST_S;
                    RVALID_M1 = RVALID_S;
                end else begin
                    RID_M0    = RID_S;
                    RRESP_M0  = RRESP_S;
                    RLAST_M0  = RLAST_S;
                    RVALID_M0 = RVALID_S;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/rom_rd_arbiter.md
Name: rom_rd_arbiter

Overview:
- Shares the single ROM AXI read-slave port between two AXI read masters: M0 (instruction fetch) and M1 (data/DMA).
- Sits between the bus interconnect and the ROM read-channel FSM.
- Arbitrates AR requests, holds the grant for the whole burst, and routes the R channel back to the granted master.
- Only one burst is outstanding at a time.

Parameters:
ID_BITS, 4, width of ARID/RID on every port
ADDR_BITS, 12, ROM word-address width (matches ROM_ADDR_BITS)
LEN_BITS, 4, burst-length field width (beats = ARLEN+1)

Ports:
ACLK  in  1  clock, all logic on the rising edge
ARESET  in  1  reset; synchronous, active-high
ARID_M0/ARID_M1  in  ID_BITS  master AR id
ARADDR_M0/ARADDR_M1  in  ADDR_BITS  master AR word address
ARLEN_M0/ARLEN_M1  in  LEN_BITS  master AR burst length
ARVALID_M0/ARVALID_M1  in  1  master AR valid
ARREADY_M0/ARREADY_M1  out  1  master AR ready
RID_M0/RID_M1  out  ID_BITS  R id returned to the master
RRESP_M0/RRESP_M1  out  2  R response returned to the master
RLAST_M0/RLAST_M1  out  1  R last returned to the master
RVALID_M0/RVALID_M1  out  1  R valid returned to the master
RREADY_M0/RREADY_M1  in  1  master R ready
ARID_S  out  ID_BITS  slave AR id
ARADDR_S  out  ADDR_BITS  slave AR address
ARLEN_S  out  LEN_BITS  slave AR burst length
ARVALID_S  out  1  slave AR valid
ARREADY_S  in  1  slave AR ready
RID_S  in  ID_BITS  slave R id
RRESP_S  in  2  slave R response
RLAST_S  in  1  slave R last
RVALID_S  in  1  slave R valid
RREADY_S  out  1  slave R ready
grant  out  1  index of the owning master; valid while busy=1
busy  out  1  high in ADDR and DATA
beat_err  out  1  sticky burst-length mismatch flag

Behaviour:
- Clock and reset: one clock, ACLK. ARESET is synchronous and active-high.
- Reset values: state=IDLE, priority pointer=M0, grant=0, busy=0, beat_err=0, all VALID/READY outputs 0, all payload registers 0.
- Reset asserted mid-burst: the block drops to IDLE on the next edge, and any outstanding beats are abandoned.
- State machine, IDLE:
  - ARREADY_Mx is high only for the selected master x, and only when ARVALID_Mx=1. The select is combinational from ARVALID and the pointer.
  - On that handshake: latch the ARID/ARADDR/ARLEN of x, set grant=x, and go to ADDR.
  - No request: stay in IDLE.
- State machine, ADDR:
  - ARVALID_S=1 with the latched payload. Payload is stable until ARREADY_S.
  - Both master ARREADYs are 0.
  - ARVALID_S&ARREADY_S moves to DATA; the beat counter loads the latched ARLEN.
  - Latency: master handshake at edge t gives ARVALID_S high from edge t+1.
- State machine, DATA:
  - RID/RRESP/RLAST/RVALID of the granted master are driven from the slave.
  - The other master sees RVALID=0, RLAST=0, RID=0, RRESP=0.
  - RREADY_S = RREADY_M[grant].
  - Each beat handshake (RVALID_S&RREADY_S) decrements the beat counter.
  - A beat with RLAST_S=1 goes to IDLE on that edge, so a new AR can be accepted the following cycle.
  - Beat counter width is LEN_BITS. On a decrement past 0 it holds at 0.
- beat_err (sticky until reset) is set when either of these occurs:
  - RLAST_S=1 on a beat with counter≠0;
  - RLAST_S=0 on a beat with counter=0.
  - In both cases the burst still ends only on RLAST_S.
- Arbitration:
  - Only one requester: that master wins.
  - Both requesting: resolved per Optional Feature.
  - The pointer updates only on the master AR handshake; pointer := the loser, so the other master gets priority next time.
- Simultaneous events:
  - An ARVALID arriving during ADDR or DATA waits; its ARREADY stays 0.
  - A master that drops ARVALID before being granted is not an error and is not remembered.

Optional Feature:
- Macro: ROM_ARB_ROUND_ROBIN_EN.
- Defined: when both masters request, the pointer-selected master wins (round robin).
- Undefined: fixed priority, M0 always wins. The pointer register is removed or unused.

Test Plan:
- Reset then M0 AR {ID=3, ADDR=0x010, LEN=3}, slave 4 beats with RLAST on beat 4, RREADY_M0=1 -> ARVALID_S one cycle after the M0 handshake with ADDR 0x010; M0 receives 4 beats with RID=3; RVALID_M1 stays 0; beat_err=0; busy falls after beat 4.
- M0 and M1 request in the same cycle, both LEN=0, repeated three times -> with ROM_ARB_ROUND_ROBIN_EN the grant order is M0, M1, M0; without it the grant order is M0, M0, M0 while M0 keeps requesting.
- M1 burst in DATA with RREADY_M1 toggling 1,0,1,0 -> RREADY_S mirrors it; the beat counter changes only on handshake cycles; ARREADY_M0 stays 0 while M0 requests.
- ADDR phase with ARREADY_S held low for 5 cycles -> ARVALID_S and the payload are stable all 5 cycles; no master ARREADY is asserted.
- LEN=2 burst where the slave asserts RLAST on beat 2 -> beat_err=1 and stays 1; the FSM returns to IDLE after beat 2; the next burst completes normally.
- ARESET asserted for 1 cycle during DATA beat 2 -> next cycle: IDLE, all VALIDs 0, beat_err=0, pointer=M0; a new M1 request is then accepted.
